// File: rtl/get_reg_pkg.sv
// -----------------------------------------------------------------------------
// get_reg_pkg
// Shared constants, types and the ABI name table for the register-name lookup.
//   NAME_CHARS : maximum characters in a register name
//   NAME_W     : packed ASCII width of a name (8 bits per character)
//   IDX_W      : width of the register index (matches executer rd/rs fields)
//   reg_name_t : right-justified, zero-padded packed ASCII name
//   ERR_NAME   : "??" returned for indices above 31
//   abi_name() : 5-bit index -> ABI mnemonic case table
// -----------------------------------------------------------------------------
package get_reg_pkg;

   localparam int NAME_CHARS = 4;
   localparam int NAME_W     = 8 * NAME_CHARS;
   localparam int IDX_W      = 6;

   typedef logic [NAME_W-1:0] reg_name_t;

   localparam reg_name_t ERR_NAME = {16'h0000, "??"};

   // Full ABI table. The top only takes the fixed names (zero/ra/sp/gp/tp)
   // from here; the numbered t/s/a groups are assembled from a letter plus
   // decimal digits so they share the digit converter with the numeric build.
   function automatic reg_name_t abi_name(input logic [4:0] num);
      reg_name_t n;
      case (num)
         5'd0 : n = "zero";
         5'd1 : n = {16'h0000, "ra"};
         5'd2 : n = {16'h0000, "sp"};
         5'd3 : n = {16'h0000, "gp"};
         5'd4 : n = {16'h0000, "tp"};
         5'd5 : n = {16'h0000, "t0"};
         5'd6 : n = {16'h0000, "t1"};
         5'd7 : n = {16'h0000, "t2"};
         5'd8 : n = {16'h0000, "s0"};
         5'd9 : n = {16'h0000, "s1"};
         5'd10: n = {16'h0000, "a0"};
         5'd11: n = {16'h0000, "a1"};
         5'd12: n = {16'h0000, "a2"};
         5'd13: n = {16'h0000, "a3"};
         5'd14: n = {16'h0000, "a4"};
         5'd15: n = {16'h0000, "a5"};
         5'd16: n = {16'h0000, "a6"};
         5'd17: n = {16'h0000, "a7"};
         5'd18: n = {16'h0000, "s2"};
         5'd19: n = {16'h0000, "s3"};
         5'd20: n = {16'h0000, "s4"};
         5'd21: n = {16'h0000, "s5"};
         5'd22: n = {16'h0000, "s6"};
         5'd23: n = {16'h0000, "s7"};
         5'd24: n = {16'h0000, "s8"};
         5'd25: n = {16'h0000, "s9"};
         5'd26: n = {8'h00, "s10"};
         5'd27: n = {8'h00, "s11"};
         5'd28: n = {16'h0000, "t3"};
         5'd29: n = {16'h0000, "t4"};
         5'd30: n = {16'h0000, "t5"};
         default: n = {16'h0000, "t6"};
      endcase
      return n;
   endfunction

endpackage

// File: rtl/get_reg_if.sv
// -----------------------------------------------------------------------------
// get_reg_if
// Request/response bundle for the register-name lookup.
//   req_valid : lookup request this cycle            (master -> slave)
//   idx       : register index to convert            (master -> slave)
//   name_vld  : name/err valid, one cycle after req  (slave -> master)
//   name      : packed ASCII name                    (slave -> master)
//   err       : index out of range (>31)             (slave -> master)
// -----------------------------------------------------------------------------
interface get_reg_if;
   import get_reg_pkg::*;

   logic             req_valid;
   logic [IDX_W-1:0] idx;
   logic             name_vld;
   reg_name_t        name;
   logic             err;

   modport master (
      output req_valid, idx,
      input  name_vld, name, err
   );

   modport slave (
      input  req_valid, idx,
      output name_vld, name, err
   );

endinterface

// File: rtl/get_reg_dec2ascii.sv
// -----------------------------------------------------------------------------
// get_reg_dec2ascii
// Converts a 5-bit value (0..31) into one or two ASCII decimal digits.
//   val    : value to convert
//   digits : right-justified ASCII, upper byte 8'h00 for single-digit values
// -----------------------------------------------------------------------------
module get_reg_dec2ascii (
   input  logic [4:0]  val,
   output logic [15:0] digits
);

   logic [1:0] tens;
   logic [3:0] ones;

   // Range compares instead of divide: only four possible tens values.
   // ASCII '0'..'9' is simply 4'h3 followed by the BCD nibble.
   always_comb begin
      tens = 2'd0;
      ones = val[3:0];
      if (val >= 5'd30) begin
         tens = 2'd3;
         ones = 4'(val - 5'd30);
      end else if (val >= 5'd20) begin
         tens = 2'd2;
         ones = 4'(val - 5'd20);
      end else if (val >= 5'd10) begin
         tens = 2'd1;
         ones = 4'(val - 5'd10);
      end

      if (tens == 2'd0)
         digits = {8'h00, 4'h3, ones};
      else
         digits = {6'b001100, tens, 4'h3, ones};
   end

endmodule

// File: rtl/get_reg.sv
// -----------------------------------------------------------------------------
// get_reg
// RISC-V integer register index -> ASCII name lookup for trace/print logic.
// One lookup per cycle, result registered one cycle after the request.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : get_reg_if.slave (req_valid/idx in, name_vld/name/err out)
// Build option: define GET_REG_NUMERIC_EN for "x0".."x31" names instead of
// ABI mnemonics; out-of-range handling and timing are the same either way.
// -----------------------------------------------------------------------------
module get_reg (
   input  logic      clk,
   input  logic      rst_n,
   get_reg_if.slave  bus
);
   import get_reg_pkg::*;

   logic [4:0]  reg_num;
   logic        out_of_range;
   logic [7:0]  prefix;
   logic [4:0]  suffix_num;
   logic        use_table;
   logic [15:0] digits;
   reg_name_t   next_name;

   assign reg_num      = bus.idx[4:0];
   assign out_of_range = |bus.idx[IDX_W-1:5];

   get_reg_dec2ascii u_dec (
      .val    (suffix_num),
      .digits (digits)
   );

   // Split the index into a group letter and the number within that group.
   // Fixed names (zero/ra/sp/gp/tp) bypass this and come from the table.
   always_comb begin
      prefix     = 8'h00;
      suffix_num = 5'd0;
      use_table  = 1'b0;
`ifdef GET_REG_NUMERIC_EN
      prefix     = "x";
      suffix_num = reg_num;
`else
      if (reg_num < 5'd5) begin
         use_table = 1'b1;
      end else if (reg_num < 5'd8) begin
         prefix     = "t";
         suffix_num = reg_num - 5'd5;
      end else if (reg_num < 5'd10) begin
         prefix     = "s";
         suffix_num = reg_num - 5'd8;
      end else if (reg_num < 5'd18) begin
         prefix     = "a";
         suffix_num = reg_num - 5'd10;
      end else if (reg_num < 5'd28) begin
         prefix     = "s";
         suffix_num = reg_num - 5'd16;
      end else begin
         prefix     = "t";
         suffix_num = reg_num - 5'd25;
      end
`endif
   end

   // Assemble the right-justified name: the letter sits directly above the
   // highest digit byte, everything above it stays zero.
   always_comb begin
      if (out_of_range)
         next_name = ERR_NAME;
      else if (use_table)
         next_name = abi_name(reg_num);
      else if (digits[15:8] == 8'h00)
         next_name = {16'h0000, prefix, digits[7:0]};
      else
         next_name = {8'h00, prefix, digits};
   end

   // Output register: valid follows the request every cycle, name/err only
   // update on an accepted request so they hold across idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.name_vld <= 1'b0;
         bus.name     <= '0;
         bus.err      <= 1'b0;
      end else begin
         bus.name_vld <= bus.req_valid;
         if (bus.req_valid) begin
            bus.name <= next_name;
            bus.err  <= out_of_range;
         end
      end
   end

endmodule

// File: tb/tb_get_reg.sv
// -----------------------------------------------------------------------------
// tb_get_reg
// Directed plus random stimulus for get_reg against a string-based model.
// -----------------------------------------------------------------------------
module tb_get_reg;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   get_reg_if bus ();

   get_reg dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   string abi_tab [32] = '{
      "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
      "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
      "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
      "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"
   };

   // Expected outputs as seen after the most recent clock edge.
   logic        exp_vld;
   logic [31:0] exp_name;
   logic        exp_err;

   function automatic logic [31:0] pack_str(input string s);
      logic [31:0] r;
      r = 32'h0;
      for (int k = 0; k < s.len(); k++)
         r = {r[23:0], s[k]};
      return r;
   endfunction

   function automatic string ref_name(input int i);
      if (i > 31)
         return "??";
`ifdef GET_REG_NUMERIC_EN
      return $sformatf("x%0d", i);
`else
      return abi_tab[i];
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".vld"},  {31'h0, bus.name_vld}, {31'h0, exp_vld});
      check({tag, ".name"}, bus.name,              exp_name);
      check({tag, ".err"},  {31'h0, bus.err},      {31'h0, exp_err});
   endtask

   // One cycle: drive on the falling edge, sample 1 time unit after rising.
   task automatic applyStimulus(input logic rv, input int i);
      @(negedge clk);
      bus.req_valid = rv;
      bus.idx       = 6'(i);
      @(posedge clk);
      #1;
      exp_vld = rv;
      if (rv) begin
         exp_name = pack_str(ref_name(i));
         exp_err  = (i > 31);
      end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.idx       = '0;
      exp_vld       = 1'b0;
      exp_name      = 32'h0;
      exp_err       = 1'b0;

      repeat (2) @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;

      // Back-to-back sweep of every legal index.
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, i);
         check_all($sformatf("sweep%0d", i));
`ifdef GET_REG_NUMERIC_EN
         if (i == 0)  check("num_x0",  bus.name, 32'h00007830);
         if (i == 9)  check("num_x9",  bus.name, 32'h00007839);
         if (i == 31) check("num_x31", bus.name, 32'h00783331);
`else
         if (i == 0)  check("abi_zero", bus.name, 32'h7A65726F);
         if (i == 2)  check("abi_sp",   bus.name, 32'h00007370);
         if (i == 27) check("abi_s11",  bus.name, 32'h00733131);
         if (i == 31) check("abi_t6",   bus.name, 32'h00007436);
`endif
      end

      // Out-of-range indices.
      applyStimulus(1'b1, 32);
      check_all("idx32");
      check("idx32_lit", bus.name, 32'h00003F3F);
      applyStimulus(1'b1, 63);
      check_all("idx63");

      // Single pulse then idle: valid for one cycle, name holds.
      applyStimulus(1'b1, 5);
      check_all("pulse");
      applyStimulus(1'b0, 40);
      check_all("idle1");
      applyStimulus(1'b0, 17);
      check_all("idle2");

      // Reset in the middle of a pending request.
      applyStimulus(1'b1, 10);
      check_all("pre_rst");
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.idx       = 6'd3;
      #1;
      rst_n    = 1'b0;
      #1;
      exp_vld  = 1'b0;
      exp_name = 32'h0;
      exp_err  = 1'b0;
      check_all("async_rst");
      @(posedge clk);
      #1;
      check_all("rst_held");
      @(negedge clk);
      rst_n         = 1'b1;
      bus.req_valid = 1'b0;
      applyStimulus(1'b0, 3);
      check_all("post_rst");

      // Random stream, mostly legal indices.
      for (int n = 0; n < 300; n++) begin
         logic rv;
         int   i;
         rv = 1'($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0)
            i = int'($urandom_range(32, 63));
         else
            i = int'($urandom_range(0, 31));
         applyStimulus(rv, i);
         check_all($sformatf("rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
